// File: rtl/compute_dispatch.sv
// Instruction dispatcher in front of compute_core. It decodes one packed instruction, issues a
// start pulse to the selected unit, holds the operand fields until that unit's done, then retires it.
module compute_dispatch #(
  parameter int ADDR_WIDTH     = 13,
  parameter int LEN_WIDTH      = 23,
  parameter int OPC_WIDTH      = 10,
  parameter int INSTR_W        = 2 + OPC_WIDTH + 4*ADDR_WIDTH + LEN_WIDTH,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [INSTR_W-1:0]    instr_data,
  output logic [1:0]            mode_compute,
  output logic [ADDR_WIDTH-1:0] addr_a_compute,
  output logic [ADDR_WIDTH-1:0] addr_b_compute,
  output logic [ADDR_WIDTH-1:0] addr_out_compute,
  output logic [ADDR_WIDTH-1:0] addr_const_compute,
  output logic [OPC_WIDTH-1:0]  opcode_compute,
  output logic [LEN_WIDTH-1:0]  len_compute,
  output logic                  start_vpu_compute,
  output logic                  start_systolic_compute,
  output logic                  start_vadd_compute,
  input  logic                  vpu_done_compute,
  input  logic                  systolic_done_compute,
  input  logic                  vadd_done_compute,
  output logic                  busy,
  output logic                  err_illegal,
  output logic                  err_timeout,
  input  logic                  err_clear,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  localparam int LEN_LSB   = 0;
  localparam int CONST_LSB = LEN_LSB + LEN_WIDTH;
  localparam int OUT_LSB   = CONST_LSB + ADDR_WIDTH;
  localparam int B_LSB     = OUT_LSB + ADDR_WIDTH;
  localparam int A_LSB     = B_LSB + ADDR_WIDTH;
  localparam int OPC_LSB   = A_LSB + ADDR_WIDTH;
  localparam int UNIT_LSB  = OPC_LSB + OPC_WIDTH;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Value the watchdog holds during the last WAIT cycle allowed before timing out.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d, addr_const_q, addr_const_d;
  logic [OPC_WIDTH-1:0]  opcode_q, opcode_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_ill_q, err_ill_d, err_to_q, err_to_d;
  logic                  set_ill, set_to, sel_done;
  logic [1:0]            unit_in;

  assign unit_in = instr_data[UNIT_LSB +: 2];

  always_comb begin
    sel_done = 1'b0;
    case (mode_q)
      2'b00:   sel_done = vpu_done_compute;
      2'b01:   sel_done = systolic_done_compute;
      2'b10:   sel_done = vadd_done_compute;
      default: sel_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    addr_out_d   = addr_out_q;
    addr_const_d = addr_const_q;
    opcode_d     = opcode_q;
    len_d        = len_q;
    wd_d         = wd_q;
    cnt_d        = cnt_q;
    set_ill      = 1'b0;
    set_to       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          if (unit_in == 2'b11) begin
            set_ill = 1'b1;
          end else begin
            mode_d       = unit_in;
            opcode_d     = instr_data[OPC_LSB +: OPC_WIDTH];
            addr_a_d     = instr_data[A_LSB +: ADDR_WIDTH];
            addr_b_d     = instr_data[B_LSB +: ADDR_WIDTH];
            addr_out_d   = instr_data[OUT_LSB +: ADDR_WIDTH];
            addr_const_d = instr_data[CONST_LSB +: ADDR_WIDTH];
            len_d        = instr_data[LEN_LSB +: LEN_WIDTH];
            state_d      = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wd_d    = '0;
      end
      S_WAIT: begin
        // A done arriving in the final watchdog cycle still retires cleanly.
        if (sel_done) begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = S_IDLE;
        end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LAST) begin
          set_to  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_ill_d = set_ill ? 1'b1 : (err_clear ? 1'b0 : err_ill_q);
    err_to_d  = set_to  ? 1'b1 : (err_clear ? 1'b0 : err_to_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'b11;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      addr_out_q   <= '0;
      addr_const_q <= '0;
      opcode_q     <= '0;
      len_q        <= '0;
      wd_q         <= '0;
      cnt_q        <= '0;
      err_ill_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      addr_out_q   <= addr_out_d;
      addr_const_q <= addr_const_d;
      opcode_q     <= opcode_d;
      len_q        <= len_d;
      wd_q         <= wd_d;
      cnt_q        <= cnt_d;
      err_ill_q    <= err_ill_d;
      err_to_q     <= err_to_d;
    end
  end

  assign instr_ready            = (state_q == S_IDLE);
  assign busy                   = (state_q != S_IDLE);
  assign start_vpu_compute      = (state_q == S_ISSUE) && (mode_q == 2'b00);
  assign start_systolic_compute = (state_q == S_ISSUE) && (mode_q == 2'b01);
  assign start_vadd_compute     = (state_q == S_ISSUE) && (mode_q == 2'b10);
  assign mode_compute           = mode_q;
  assign addr_a_compute         = addr_a_q;
  assign addr_b_compute         = addr_b_q;
  assign addr_out_compute       = addr_out_q;
  assign addr_const_compute     = addr_const_q;
  assign opcode_compute         = opcode_q;
  assign len_compute            = len_q;
  assign err_illegal            = err_ill_q;
  assign err_timeout            = err_to_q;
  assign retired_count          = cnt_q;

endmodule
